// File: rtl/min_max_pkg.sv
// Shared types and the LED bar decoder for the min/max ramp display.
package min_max_pkg;

  typedef enum logic [1:0] {
    COM_NORMAL = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } com_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } state_t;

  virtual class bar_c #(parameter int VALSIZE = 4);
    localparam int NLEDS = 2**VALSIZE;

    // Indices are widened by one bit so cur_v+1 never wraps into the bar.
    static function logic [NLEDS-1:0] bar_leds(input com_t com,
                                               input logic [VALSIZE-1:0] min_v,
                                               input logic [VALSIZE-1:0] max_v,
                                               input logic [VALSIZE-1:0] cur_v,
                                               input logic osc);
      logic [NLEDS-1:0] leds;
      logic [VALSIZE:0] idx;
      logic [VALSIZE:0] blink_lo;
      leds = '0;
      if (({1'b0, cur_v} + {{VALSIZE{1'b0}}, 1'b1}) > {1'b0, min_v}) begin
        blink_lo = {1'b0, cur_v} + {{VALSIZE{1'b0}}, 1'b1};
      end else begin
        blink_lo = {1'b0, min_v};
      end
      for (int i = 0; i < NLEDS; i++) begin
        idx = (VALSIZE+1)'(i);
        case (com)
          COM_NORMAL: begin
            if (idx >= {1'b0, min_v} && idx <= {1'b0, cur_v}) begin
              leds[i] = 1'b1;
            end else if (idx >= blink_lo && idx <= {1'b0, max_v}) begin
              leds[i] = osc;
            end else begin
              leds[i] = 1'b0;
            end
          end
          COM_LINEAR: leds[i] = (idx <= {1'b0, cur_v});
          COM_OFF:    leds[i] = 1'b0;
          COM_ON:     leds[i] = 1'b1;
          default:    leds[i] = 1'b0;
        endcase
      end
      return leds;
    endfunction
  endclass

endpackage

// File: rtl/min_max_osc_div.sv
// Free-running blink oscillator: osc toggles every BLINK_DIV clock cycles.
module min_max_osc_div #(
  parameter int BLINK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic osc_o
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          osc_r;

  // Half-period counter and oscillator flip-flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
      osc_r <= 1'b0;
    end else if (cnt_r == TERM) begin
      cnt_r <= '0;
      osc_r <= ~osc_r;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign osc_o = osc_r;

endmodule

// File: rtl/min_max_ramp_display.sv
// Min/max LED bar with a ramped displayed value and blinking above-value zone.
// Build option MIN_MAX_EXT_OSC_EN: blink source comes from osc_i instead of the divider.
module min_max_ramp_display
  import min_max_pkg::*;
#(
  parameter int VALSIZE   = 4,
  parameter int STEP_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
`ifdef MIN_MAX_EXT_OSC_EN
  input  logic                    osc_i,
`endif
  input  logic                    load_i,
  input  logic [1:0]              com_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic [VALSIZE-1:0]      val_i,
  output logic [2**VALSIZE-1:0]   leds_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_TERM = SW'(STEP_DIV - 1);

  com_t                  com_r, com_s;
  logic [VALSIZE-1:0]    min_r, min_s, max_r, max_s, tgt_r, tgt_s, cur_r, cur_s;
  state_t                state_r, state_s;
  logic [SW-1:0]         step_r, step_s;
  logic                  err_r, err_s, busy_r, load_ok_s, osc_s;
  logic [2**VALSIZE-1:0] leds_r, leds_s;

`ifdef MIN_MAX_EXT_OSC_EN
  assign osc_s = osc_i;
`else
  min_max_osc_div #(.BLINK_DIV(BLINK_DIV)) u_osc_div (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .osc_o (osc_s)
  );
`endif

  assign load_ok_s = (min_i <= max_i) && (min_i <= val_i) && (val_i <= max_i);

  // Ramp stepping, with a valid load overriding config, direction and step phase.
  always_comb begin
    com_s   = com_r;
    min_s   = min_r;
    max_s   = max_r;
    tgt_s   = tgt_r;
    cur_s   = cur_r;
    state_s = state_r;
    step_s  = step_r;
    err_s   = err_r;
    case (state_r)
      RAMP_UP, RAMP_DOWN: begin
        if (step_r == STEP_TERM) begin
          step_s = '0;
          cur_s  = (state_r == RAMP_UP) ? (cur_r + 1'b1) : (cur_r - 1'b1);
          if (cur_s == tgt_r) begin
            state_s = IDLE;
          end else begin
            state_s = state_r;
          end
        end else begin
          step_s = step_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (load_i) begin
      if (load_ok_s) begin
        com_s  = com_t'(com_i);
        min_s  = min_i;
        max_s  = max_i;
        tgt_s  = val_i;
        cur_s  = cur_r;
        step_s = '0;
        err_s  = 1'b0;
        if (val_i > cur_r) begin
          state_s = RAMP_UP;
        end else if (val_i < cur_r) begin
          state_s = RAMP_DOWN;
        end else begin
          state_s = IDLE;
        end
      end else begin
        err_s = 1'b1;
      end
    end else begin
      err_s = err_r;
    end
  end

  // Bar decode from the current registers; registered one cycle later.
  always_comb begin
    leds_s = bar_c#(VALSIZE)::bar_leds(com_r, min_r, max_r, cur_r, osc_s);
  end

  // Configuration, ramp state and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      com_r   <= COM_OFF;
      min_r   <= '0;
      max_r   <= '1;
      tgt_r   <= '0;
      cur_r   <= '0;
      state_r <= IDLE;
      step_r  <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      leds_r  <= '0;
    end else begin
      com_r   <= com_s;
      min_r   <= min_s;
      max_r   <= max_s;
      tgt_r   <= tgt_s;
      cur_r   <= cur_s;
      state_r <= state_s;
      step_r  <= step_s;
      err_r   <= err_s;
      busy_r  <= (state_s != IDLE);
      leds_r  <= leds_s;
    end
  end

  assign leds_o = leds_r;
  assign busy_o = busy_r;
  assign err_o  = err_r;

endmodule

// File: tb/tb_min_max_ramp_display.sv
// Scoreboard bench for min_max_ramp_display against a closed-form ramp model.
module tb_min_max_ramp_display;

  localparam int VALSIZE   = 4;
  localparam int STEP_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int NL        = 2**VALSIZE;

  typedef struct packed {
    logic [NL-1:0] leds;
    logic          busy;
    logic          err;
  } exp_t;

  logic clk, rst, load_i, osc_i;
  logic [1:0] com_i;
  logic [VALSIZE-1:0] min_i, max_i, val_i;
  logic [NL-1:0] leds_o;
  logic busy_o, err_o;

  min_max_ramp_display #(.VALSIZE(VALSIZE), .STEP_DIV(STEP_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
`ifdef MIN_MAX_EXT_OSC_EN
    .osc_i  (osc_i),
`endif
    .load_i (load_i),
    .com_i  (com_i),
    .min_i  (min_i),
    .max_i  (max_i),
    .val_i  (val_i),
    .leds_o (leds_o),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Model: configuration plus ramp described by start value, target and load edge.
  int m_com, m_min, m_max, m_tgt, m_c0, m_l, n;
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int cur_at(input int e);
    int steps, d;
    steps = (e - m_l) / STEP_DIV;
    d = m_tgt - m_c0;
    if (d >= 0) return m_c0 + ((steps < d) ? steps : d);
    else        return m_c0 - ((steps < -d) ? steps : -d);
  endfunction

  function automatic logic [NL-1:0] exp_leds(input int com, input int mn, input int mx,
                                              input int cur, input bit o);
    logic [NL-1:0] l;
    l = '0;
    for (int i = 0; i < NL; i++) begin
      case (com)
        0: l[i] = (i >= mn && i <= cur) ? 1'b1 : ((i > cur && i >= mn && i <= mx) ? o : 1'b0);
        1: l[i] = (i <= cur);
        3: l[i] = 1'b1;
        default: l[i] = 1'b0;
      endcase
    end
    return l;
  endfunction

  task automatic model_reset();
    m_com = 2; m_min = 0; m_max = NL - 1; m_tgt = 0; m_c0 = 0; m_l = 0; m_err = 1'b0; n = 0;
  endtask

  // One clock: drive inputs at the negedge, push the expected post-edge outputs.
  task automatic cycle(input bit ld, input int c, input int mn, input int mx, input int v);
    exp_t e;
    int cur_pre;
    bit o;
    load_i = ld;
    com_i  = 2'(c);
    min_i  = 4'(mn);
    max_i  = 4'(mx);
    val_i  = 4'(v);
`ifdef MIN_MAX_EXT_OSC_EN
    osc_i = 1'($urandom_range(0, 1));
    o = osc_i;
`else
    osc_i = 1'b0;
    o = ((n / BLINK_DIV) % 2) == 1;
`endif
    cur_pre = cur_at(n);
    e.leds = exp_leds(m_com, m_min, m_max, cur_pre, o);
    if (ld) begin
      if (mn <= mx && mn <= v && v <= mx) begin
        m_com = c; m_min = mn; m_max = mx; m_tgt = v;
        m_c0 = cur_pre; m_l = n + 1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    n = n + 1;
    e.busy = (cur_at(n) != m_tgt);
    e.err  = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 0, 0, 0, 0);
  endtask

  // Monitor: pop one expectation per clock and compare just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("leds", 32'(leds_o), 32'(mon_e.leds));
      chk("busy", 32'(busy_o), 32'(mon_e.busy));
      chk("err",  32'(err_o),  32'(mon_e.err));
    end
  end

  initial begin
    int c, mn, mx, v;
    bit ld;
    rst = 1'b1; load_i = 1'b0; com_i = 2'b00; min_i = '0; max_i = '0; val_i = '0; osc_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_leds", 32'(leds_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    model_reset();
    idle(20);

    cycle(1'b1, 0, 3, 12, 8);
    idle(40);
    cycle(1'b1, 0, 10, 5, 7);
    idle(3);
    cycle(1'b1, 0, 0, 15, 8);
    idle(22);
    cycle(1'b1, 0, 0, 15, 2);
    idle(16);
    cycle(1'b1, 0, 0, 15, 14);
    idle(5);
    cycle(1'b1, 3, 0, 15, 14);
    idle(5);
    cycle(1'b1, 1, 0, 15, 15);
    idle(70);
    cycle(1'b1, 0, 4, 9, 6);
    cycle(1'b1, 0, 9, 4, 6);
    cycle(1'b1, 0, 2, 13, 13);
    idle(10);

    repeat (500) begin
      ld = ($urandom_range(0, 5) == 0);
      c  = $urandom_range(0, 3);
      mn = $urandom_range(0, NL - 1);
      if ($urandom_range(0, 9) < 7) begin
        mx = $urandom_range(mn, NL - 1);
        v  = $urandom_range(mn, mx);
      end else begin
        mx = $urandom_range(0, NL - 1);
        v  = $urandom_range(0, NL - 1);
      end
      cycle(ld, c, mn, mx, v);
    end

    cycle(1'b1, 3, 0, 15, 15);
    cycle(1'b1, 3, 0, 15, 0);
    idle(3);
    cycle(1'b1, 0, 9, 1, 0);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_leds", 32'(leds_o), 32'h0);
    chk("async_busy", 32'(busy_o), 32'h0);
    chk("async_err",  32'(err_o),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
